// File: rtl/bounce_generator.sv
// bounce_generator
//   Turns a clean level request into a switch-like bouncing signal: after an
//   accepted start the output goes to the target level, then alternates
//   target / !target for 2*BOUNCE_COUNT phases, lands on target, holds it for
//   SETTLE_WAIT cycles and emits a one-cycle settled pulse.
//
//   Phase width W = 1 + (lfsr % MAX_GLITCH), sampled at each phase start from
//   an 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) that free-runs every cycle.
//
//   Build option: define BOUNCE_GEN_FIXED_WIDTH_EN to make every phase
//   exactly MAX_GLITCH cycles wide. The LFSR is then removed and LFSR_SEED
//   is unused.
module bounce_generator #(
    parameter int unsigned BOUNCE_COUNT = 4,
    parameter int unsigned MAX_GLITCH   = 3,
    parameter int unsigned SETTLE_WAIT  = 8,
    parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start,
    input  logic target,
    output logic noisysignal,
    output logic busy,
    output logic settled
);

    // Counters must hold max(MAX_GLITCH, SETTLE_WAIT, 2*BOUNCE_COUNT).
    localparam int unsigned MAX_A = (MAX_GLITCH > SETTLE_WAIT) ? MAX_GLITCH : SETTLE_WAIT;
    localparam int unsigned MAX_V = (MAX_A > 2 * BOUNCE_COUNT) ? MAX_A : 2 * BOUNCE_COUNT;
    localparam int unsigned CW    = $clog2(MAX_V + 1);

    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_WAIT - 1);
    localparam logic [CW-1:0] LAST_PHASE  = (BOUNCE_COUNT > 0) ? CW'(2 * BOUNCE_COUNT - 1) : '0;
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);

    if (MAX_GLITCH < 1) begin : g_bad_max_glitch
        $error("bounce_generator: MAX_GLITCH must be >= 1");
    end
    if (SETTLE_WAIT < 1) begin : g_bad_settle_wait
        $error("bounce_generator: SETTLE_WAIT must be >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_BOUNCE,
        S_SETTLE
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_noisy;
    logic          w_noisy_nxt;
    logic          r_busy;
    logic          w_busy_nxt;
    logic          r_settled;
    logic          w_settled_nxt;
    logic          r_target;
    logic          w_target_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [CW-1:0] r_phase;
    logic [CW-1:0] w_phase_nxt;
    logic [CW-1:0] w_wm1;          // width of the phase starting at this edge, minus one

`ifdef BOUNCE_GEN_FIXED_WIDTH_EN
    assign w_wm1 = CW'(MAX_GLITCH - 1);
`else
    if (LFSR_SEED == 8'h00) begin : g_bad_seed
        $error("bounce_generator: LFSR_SEED must be non-zero");
    end

    logic [7:0] r_lfsr;
    logic       w_lfsr_fb;

    assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    // Free-running pseudo-random source for glitch widths, shifts every cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
        end
    end

    assign w_wm1 = CW'({24'd0, r_lfsr} % MAX_GLITCH);
`endif

    // Next-state and next-output decode for the IDLE/BOUNCE/SETTLE sequence.
    always_comb begin
        w_state_nxt   = r_state;
        w_noisy_nxt   = r_noisy;
        w_busy_nxt    = r_busy;
        w_settled_nxt = 1'b0;
        w_target_nxt  = r_target;
        w_cnt_nxt     = r_cnt;
        w_phase_nxt   = r_phase;

        case (r_state)
            S_IDLE: begin
                w_busy_nxt = 1'b0;
                if (start) begin
                    if (target != r_noisy) begin
                        w_target_nxt = target;
                        w_noisy_nxt  = target;
                        w_busy_nxt   = 1'b1;
                        w_phase_nxt  = '0;
                        if (BOUNCE_COUNT == 0) begin
                            w_state_nxt = S_SETTLE;
                            w_cnt_nxt   = SETTLE_LOAD;
                        end else begin
                            w_state_nxt = S_BOUNCE;
                            w_cnt_nxt   = w_wm1;
                        end
                    end else begin
                        // Already at the requested level: report settled at once.
                        w_settled_nxt = 1'b1;
                    end
                end
            end

            S_BOUNCE: begin
                if (r_cnt == '0) begin
                    if (r_phase == LAST_PHASE) begin
                        w_noisy_nxt = r_target;
                        w_state_nxt = S_SETTLE;
                        w_cnt_nxt   = SETTLE_LOAD;
                    end else begin
                        w_noisy_nxt = ~r_noisy;
                        w_phase_nxt = r_phase + CNT_ONE;
                        w_cnt_nxt   = w_wm1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end

            S_SETTLE: begin
                if (r_cnt == '0) begin
                    w_settled_nxt = 1'b1;
                    w_busy_nxt    = 1'b0;
                    w_state_nxt   = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset aborts any sequence immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_noisy   <= 1'b0;
            r_busy    <= 1'b0;
            r_settled <= 1'b0;
            r_target  <= 1'b0;
            r_cnt     <= '0;
            r_phase   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_noisy   <= w_noisy_nxt;
            r_busy    <= w_busy_nxt;
            r_settled <= w_settled_nxt;
            r_target  <= w_target_nxt;
            r_cnt     <= w_cnt_nxt;
            r_phase   <= w_phase_nxt;
        end
    end

    assign noisysignal = r_noisy;
    assign busy        = r_busy;
    assign settled     = r_settled;

endmodule

// File: tb/tb_bounce_generator.sv
// Bench for bounce_generator (default LFSR build). Two instances: defaults
// (BOUNCE_COUNT=4) and BOUNCE_COUNT=0. For every accepted request the bench
// expands the full expected per-cycle trajectory of {noisysignal,busy,settled}
// from its own LFSR model and queues it; a checker pops one entry per edge.
module tb_bounce_generator;

    localparam int BC0 = 4;
    localparam int BC1 = 0;
    localparam int MG  = 3;
    localparam int SW  = 8;

    logic clk = 1'b0;
    logic reset_n;
    logic start0, target0, start1, target1;
    logic noisy0, busy0, settled0;
    logic noisy1, busy1, settled1;

    always #5 clk = ~clk;

    bounce_generator u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start0),
        .target      (target0),
        .noisysignal (noisy0),
        .busy        (busy0),
        .settled     (settled0)
    );

    bounce_generator #(
        .BOUNCE_COUNT (BC1)
    ) u_dut_bc0 (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start1),
        .target      (target1),
        .noisysignal (noisy1),
        .busy        (busy1),
        .settled     (settled1)
    );

    typedef logic [2:0] exp_t;   // {noisysignal, busy, settled}

    exp_t q0[$];
    exp_t q1[$];
    exp_t traj[$];

    int   errors = 0;
    int   checks = 0;
    logic cur0 = 1'b0;
    logic cur1 = 1'b0;
    logic prev0 = 1'b0;
    logic prev1 = 1'b0;
    int   chg0 = 0, chg1 = 0, pul0 = 0, pul1 = 0;
    logic [7:0] m_lfsr;

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    // Reference LFSR: value held before the next posedge.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) m_lfsr <= 8'hA5;
        else          m_lfsr <= lfsr_step(m_lfsr);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard consumer and edge/pulse monitor.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (reset_n) begin
            if (q0.size() > 0) begin
                e = q0.pop_front();
                check("bc4_outputs", 32'({noisy0, busy0, settled0}), 32'(e));
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                check("bc0_outputs", 32'({noisy1, busy1, settled1}), 32'(e));
            end
            if (noisy0 !== prev0) chg0++;
            if (noisy1 !== prev1) chg1++;
            prev0 = noisy0;
            prev1 = noisy1;
            if (settled0) pul0++;
            if (settled1) pul1++;
        end
    end

    // Expected trajectory from the edge that accepts start onward.
    task automatic gen_traj(input int bc, input logic tgt, input logic [7:0] l0);
        logic [7:0] l;
        logic       lv;
        int         w;
        l  = l0;
        lv = tgt;
        traj.delete();
        for (int p = 0; p < 2 * bc; p++) begin
            w = 1 + (int'(l) % MG);
            for (int k = 0; k < w; k++) begin
                traj.push_back({lv, 1'b1, 1'b0});
                l = lfsr_step(l);
            end
            lv = ~lv;
        end
        for (int k = 0; k < SW; k++) traj.push_back({tgt, 1'b1, 1'b0});
        traj.push_back({tgt, 1'b0, 1'b1});
    endtask

    task automatic set_in(input int d, input logic s, input logic t);
        if (d == 0) begin start0 = s; target0 = t; end
        else        begin start1 = s; target1 = t; end
    endtask

    task automatic push(input int d, input exp_t e);
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Idle gap, one start request, then random start/target noise while busy.
    task automatic run_row(input int d, input logic tgt, input int gap);
        int   n;
        logic cur;
        cur = (d == 0) ? cur0 : cur1;
        repeat (gap) begin
            @(negedge clk);
            set_in(d, 1'b0, tgt);
            push(d, {cur, 2'b00});
        end
        @(negedge clk);
        set_in(d, 1'b1, tgt);
        if (tgt !== cur) begin
            gen_traj((d == 0) ? BC0 : BC1, tgt, m_lfsr);
        end else begin
            traj.delete();
            traj.push_back({cur, 2'b01});
        end
        n = traj.size();
        foreach (traj[i]) push(d, traj[i]);
        if (d == 0) cur0 = tgt;
        else        cur1 = tgt;
        for (int i = 1; i < n; i++) begin
            @(negedge clk);
            set_in(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        @(posedge clk);
        #2;
        set_in(d, 1'b0, tgt);
    endtask

    typedef struct {
        int   d;
        logic tgt;
        int   gap;
        logic exp_final;
        int   exp_chg;
        int   exp_pul;
    } row_t;

    row_t rows[9];

    initial begin
        rows[0] = '{d: 0, tgt: 1'b1, gap: 2, exp_final: 1'b1, exp_chg: 9, exp_pul: 1};
        rows[1] = '{d: 0, tgt: 1'b0, gap: 0, exp_final: 1'b0, exp_chg: 9, exp_pul: 1};
        rows[2] = '{d: 0, tgt: 1'b0, gap: 3, exp_final: 1'b0, exp_chg: 0, exp_pul: 1};
        rows[3] = '{d: 0, tgt: 1'b1, gap: 0, exp_final: 1'b1, exp_chg: 9, exp_pul: 1};
        rows[4] = '{d: 0, tgt: 1'b1, gap: 1, exp_final: 1'b1, exp_chg: 0, exp_pul: 1};
        rows[5] = '{d: 1, tgt: 1'b1, gap: 2, exp_final: 1'b1, exp_chg: 1, exp_pul: 1};
        rows[6] = '{d: 1, tgt: 1'b1, gap: 0, exp_final: 1'b1, exp_chg: 0, exp_pul: 1};
        rows[7] = '{d: 1, tgt: 1'b0, gap: 0, exp_final: 1'b0, exp_chg: 1, exp_pul: 1};
        rows[8] = '{d: 0, tgt: 1'b0, gap: 5, exp_final: 1'b0, exp_chg: 9, exp_pul: 1};

        reset_n = 1'b0;
        start0 = 1'b0; target0 = 1'b0;
        start1 = 1'b0; target1 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("reset_noisy0",   32'(noisy0),   32'd0);
        check("reset_busy0",    32'(busy0),    32'd0);
        check("reset_settled0", 32'(settled0), 32'd0);
        check("reset_noisy1",   32'(noisy1),   32'd0);
        check("reset_busy1",    32'(busy1),    32'd0);
        check("reset_settled1", 32'(settled1), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            if (rows[i].d == 0) begin chg0 = 0; pul0 = 0; end
            else                begin chg1 = 0; pul1 = 0; end
            run_row(rows[i].d, rows[i].tgt, rows[i].gap);
            if (rows[i].d == 0) begin
                check($sformatf("row%0d_final", i),   32'(noisy0), 32'(rows[i].exp_final));
                check($sformatf("row%0d_changes", i), 32'(chg0),   32'(rows[i].exp_chg));
                check($sformatf("row%0d_pulses", i),  32'(pul0),   32'(rows[i].exp_pul));
            end else begin
                check($sformatf("row%0d_final", i),   32'(noisy1), 32'(rows[i].exp_final));
                check($sformatf("row%0d_changes", i), 32'(chg1),   32'(rows[i].exp_chg));
                check($sformatf("row%0d_pulses", i),  32'(pul1),   32'(rows[i].exp_pul));
            end
        end

        // Abort mid-bounce with reset: outputs clear without a clock edge.
        @(negedge clk);
        set_in(0, 1'b1, 1'b1);
        gen_traj(BC0, 1'b1, m_lfsr);
        foreach (traj[i]) q0.push_back(traj[i]);
        repeat (10) begin
            @(negedge clk);
            set_in(0, 1'b0, 1'b1);
        end
        pul0 = 0;
        reset_n = 1'b0;
        q0.delete();
        #1;
        check("abort_noisy0",   32'(noisy0),   32'd0);
        check("abort_busy0",    32'(busy0),    32'd0);
        check("abort_settled0", 32'(settled0), 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("abort_hold", 32'({noisy0, busy0, settled0}), 32'd0);
        end
        check("abort_no_pulse", 32'(pul0), 32'd0);
        prev0 = 1'b0; prev1 = 1'b0;
        cur0 = 1'b0;  cur1 = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        chg0 = 0; pul0 = 0;
        run_row(0, 1'b1, 1);
        check("post_reset_final",   32'(noisy0), 32'd1);
        check("post_reset_changes", 32'(chg0),   32'd9);
        check("post_reset_pulses",  32'(pul0),   32'd1);

        repeat (2) @(negedge clk);
        check("scoreboard_drained", 32'(q0.size() + q1.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
